rr_arbiter32: RTL and testbench

RR_ARBITER32 -- requirements
Module: rr_arbiter32

---
 rtl/rr_arbiter32.sv | 107 ++++++++++
 tb/tb_rr_arbiter32.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter32.sv
// rr_arbiter32: 32-way round-robin arbiter with registered one-hot grant,
// owner-driven release (Done / request drop) and a forced release after
// MAX_HOLD busy cycles. The pointer moves to one past the released owner,
// which makes the released requester lowest priority on the next pick.
module rr_arbiter32 #(
  parameter int MAX_HOLD = 255
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [31:0] Req,
  input  logic        Done,
  output logic [31:0] Grant,
  output logic [4:0]  GrantCode,
  output logic        GrantValid,
  output logic        Timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Hold counter reaches this value on the last permitted busy cycle.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state, state_nxt;
  logic [4:0]  ptr, ptr_nxt;
  logic [7:0]  hold, hold_nxt;
  logic [31:0] grant_nxt;
  logic [4:0]  code_nxt;
  logic        valid_nxt;
  logic        timeout_nxt;

  logic [4:0]  win_code;
  logic        owner_req;
  logic        hold_hit;
  logic        release_now;

  // Pick the first set request starting at ptr and wrapping; scanning from
  // the far end down lets the nearest requester overwrite earlier hits.
  always_comb begin
    win_code = '0;
    for (int i = 31; i >= 0; i--) begin
      if (Req[ptr + 5'(i)]) win_code = ptr + 5'(i);
    end
  end

  assign owner_req   = Req[GrantCode];
  assign hold_hit    = (hold == HOLD_LAST);
  assign release_now = Done | ~owner_req | hold_hit;

  // Next-state and next-output logic; Done is only meaningful while busy.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold;
    grant_nxt   = Grant;
    code_nxt    = GrantCode;
    valid_nxt   = GrantValid;
    timeout_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (|Req) begin
          state_nxt = BUSY;
          code_nxt  = win_code;
          grant_nxt = 32'h1 << win_code;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_nxt   = IDLE;
          ptr_nxt     = GrantCode + 5'd1;
          grant_nxt   = '0;
          code_nxt    = '0;
          valid_nxt   = 1'b0;
          hold_nxt    = '0;
          // Owner-driven release wins over the hold limit.
          timeout_nxt = hold_hit & ~Done & owner_req;
        end else begin
          hold_nxt = hold + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer, counter and registered outputs; reset clears everything.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      ptr        <= '0;
      hold       <= '0;
      Grant      <= '0;
      GrantCode  <= '0;
      GrantValid <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      hold       <= hold_nxt;
      Grant      <= grant_nxt;
      GrantCode  <= code_nxt;
      GrantValid <= valid_nxt;
      Timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter32.sv
// tb_rr_arbiter32: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a behavioural model.
module tb_rr_arbiter32;
  localparam int MAXH = 4;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [31:0] Req = '0;
  logic        Done = 1'b0;
  logic [31:0] Grant;
  logic [4:0]  GrantCode;
  logic        GrantValid;
  logic        Timeout;

  int n_chk = 0;
  int n_fail = 0;

  rr_arbiter32 #(.MAX_HOLD(MAXH)) dut (
    .Clock(Clock), .Resetn(Resetn), .Req(Req), .Done(Done),
    .Grant(Grant), .GrantCode(GrantCode), .GrantValid(GrantValid),
    .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner index, pointer and busy-cycle count as plain integers.
  bit m_valid = 0;
  int m_code = 0;
  int m_ptr = 0;
  int m_hold = 0;
  bit m_to = 0;

  function automatic int first_from(input logic [31:0] r, input int p);
    for (int k = 0; k < 32; k++)
      if (r[(p + k) % 32]) return (p + k) % 32;
    return -1;
  endfunction

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_valid <= 0; m_code <= 0; m_ptr <= 0; m_hold <= 0; m_to <= 0;
    end else if (!m_valid) begin
      m_to <= 0;
      if (Req != 0) begin
        m_valid <= 1;
        m_code  <= first_from(Req, m_ptr);
        m_hold  <= 0;
      end
    end else begin
      if (Done || !Req[m_code] || m_hold == MAXH - 1) begin
        m_valid <= 0;
        m_ptr   <= (m_code + 1) % 32;
        m_to    <= !Done && Req[m_code];
        m_code  <= 0;
        m_hold  <= 0;
      end else begin
        m_hold <= m_hold + 1;
        m_to   <= 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Clock) begin
    chk("grant", Grant, m_valid ? (32'h1 << m_code) : 32'h0);
    chk("code", {27'h0, GrantCode}, m_valid ? 32'(m_code) : 32'h0);
    chk("valid", {31'h0, GrantValid}, {31'h0, m_valid});
    chk("timeout", {31'h0, Timeout}, {31'h0, m_to});
    chk("onehot", {31'h0, $onehot0(Grant)}, 32'h1);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    #1;
    chk("rst_grant", Grant, 32'h0);
    chk("rst_valid", {31'h0, GrantValid}, 32'h0);
    chk("rst_code", {27'h0, GrantCode}, 32'h0);
    chk("rst_timeout", {31'h0, Timeout}, 32'h0);
    step();
    Resetn = 1'b1;
  endtask

  initial begin
    // Basic pick and pointer advance.
    #2;
    do_reset();
    Req = 32'h5;
    step(); chk("t26_g0", Grant, 32'h1); chk("t26_c0", {27'h0, GrantCode}, 32'd0);
    Done = 1;
    step(); chk("t26_idle", {31'h0, GrantValid}, 32'h0);
    Done = 0;
    step(); chk("t26_g2", Grant, 32'h4); chk("t26_c2", {27'h0, GrantCode}, 32'd2);
    Done = 1; step(); Done = 0;

    // Wrap from owner 31 back to 0.
    Req = 32'h8000_0000;
    step(); chk("t27_c31", {27'h0, GrantCode}, 32'd31);
    Req = 32'h8000_0001; Done = 1;
    step(); chk("t27_idle", {31'h0, GrantValid}, 32'h0);
    Done = 0;
    step(); chk("t27_c0", {27'h0, GrantCode}, 32'd0);
    Req = 32'h0; step(); step();

    // Full rotation with Done held high.
    Req = '0; do_reset();
    Req = 32'hFFFF_FFFF; Done = 1;
    for (int k = 0; k <= 32; k++) begin
      step();
      chk("t28_code", {27'h0, GrantCode}, 32'(k % 32));
      chk("t28_v1", {31'h0, GrantValid}, 32'h1);
      step();
      chk("t28_v0", {31'h0, GrantValid}, 32'h0);
    end
    Done = 0; Req = '0; step();

    // Hold limit forces release.
    do_reset();
    Req = 32'h10;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t29_held", {31'h0, GrantValid}, 32'h1);
      chk("t29_noto", {31'h0, Timeout}, 32'h0);
    end
    step();
    chk("t29_rel", {31'h0, GrantValid}, 32'h0);
    chk("t29_to", {31'h0, Timeout}, 32'h1);
    step();
    chk("t29_regrant", {27'h0, GrantCode}, 32'd4);
    chk("t29_to_off", {31'h0, Timeout}, 32'h0);
    Req = '0; step(); step();

    // Owner drops its request.
    do_reset();
    Req = 32'h80;
    step(); chk("t30_c7", {27'h0, GrantCode}, 32'd7);
    Req = 32'h08;
    step();
    chk("t30_rel", {31'h0, GrantValid}, 32'h0);
    chk("t30_noto", {31'h0, Timeout}, 32'h0);
    step(); chk("t30_c3", {27'h0, GrantCode}, 32'd3);
    Req = '0; step(); step();

    // Asynchronous reset in the middle of a grant.
    do_reset();
    Req = 32'h100;
    step(); chk("t31_c8", {27'h0, GrantCode}, 32'd8);
    #1 Resetn = 1'b0;
    #1;
    chk("t31_async_g", Grant, 32'h0);
    chk("t31_async_v", {31'h0, GrantValid}, 32'h0);
    chk("t31_async_to", {31'h0, Timeout}, 32'h0);
    step();
    Resetn = 1'b1;
    step(); chk("t31_regrant", {27'h0, GrantCode}, 32'd8);
    chk("t31_regrant_v", {31'h0, GrantValid}, 32'h1);

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: Req = '0;
          1: Req = 32'h1 << $urandom_range(0, 31);
          2: Req = $urandom();
          default: Req = $urandom() & $urandom();
        endcase
      end
      Done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
